inport_vc_buffer: RTL and testbench
===================================

Name: inport_vc_buffer

Overview:
Per-virtual-channel input FIFO inside an input port. Sits directly upstream of the input port's output interface and supplies that interface's per-VC data, new and sent_req bits. One instance per VC; the no_vc instances are concatenated into the interface's outdatas/news/sent_reqs buses. The block stores incoming phits, tracks packet boundaries with a small FSM, and raises a route request while a head phit waits. When the output port calls this VC, it pops one phit into a registered output stage and returns a credit upstream.

Parameters:
phit_size, 16, width of one phit
buf_depth, 8, FIFO depth in phits (power of two, >=2)
log2_buf_depth, 3, log2(buf_depth)
floorplusone_log2_no_vc, 4, width of VC index fields (kept for bus compatibility)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_data  input  phit_size  incoming phit
in_valid  input  1  write strobe for in_data
in_new  input  1  in_data is a packet head phit
in_tail  input  1  in_data is a packet tail phit (head+tail both set = single-phit packet)
call_invc  input  1  pop request from the output interface (its per-VC call_invc bit)
ok  input  1  route/output-port grant for the pending head
outdata  output  phit_size  registered popped phit
new  output  1  registered: outdata is a head phit
sent_req  output  1  registered: outdata holds a valid popped phit
route_req  output  1  head phit at FIFO front awaiting grant
full  output  1  FIFO holds buf_depth phits
empty  output  1  FIFO holds 0 phits
credit_out  output  1  one-cycle pulse per popped phit, to upstream link
overflow  output  1  sticky: write attempted while full and not popping

Behaviour:
- Reset (async, rst=1): rd/wr pointers=0, count=0, state=IDLE, outdata=0, new=0, sent_req=0, credit_out=0, overflow=0. Reset mid-packet discards all stored phits.
- Storage: each entry = {tail, new, data}, phit_size+2 bits. Count is log2_buf_depth+1 bits. Pointers wrap modulo buf_depth.
- Write: when in_valid and (not full or pop this cycle), store the entry at wr_ptr. When in_valid, full and no pop, drop the phit and set overflow (cleared only by rst).
- Pop condition: call_invc and not empty and state==ACTIVE. On pop, the front entry is loaded into outdata/new; sent_req=1 the next cycle; credit_out=1 the next cycle. Latency from call_invc to outdata is 1 cycle, matching the interface's registered select.
- No pop in a cycle: sent_req=0 and new=0 next cycle; outdata holds its last value.
- call_invc when empty or not ACTIVE: ignored, no pointer change, sent_req=0 next cycle.
- Simultaneous write and pop: both take effect; count unchanged; legal at full and at empty+1.
- FSM:
  - IDLE: if not empty and front.new -> REQ. If front is non-head (protocol error), stay in IDLE and discard it silently at 1 phit/cycle, with credit_out pulsed.
  - REQ: route_req=1 (combinational from state). ok -> ACTIVE next cycle. ok in any other state is ignored.
  - ACTIVE: pops permitted. Popping an entry with tail=1 -> IDLE next cycle. A head+tail phit popped in the same cycle it becomes ACTIVE is legal.
- full = (count==buf_depth); empty = (count==0); both combinational from count.

Optional Feature:
INPORT_VC_BUF_BYPASS_EN:
- Defined: in ACTIVE with empty=1, in_valid=1 and call_invc=1 in the same cycle, in_data/in_new bypass the RAM directly into the output register. No write occurs, credit_out pulses, and a tail bypass returns the FSM to IDLE.
- Undefined: that cycle writes only; the pop is ignored because the FIFO is empty, and the phit emerges on a later call.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with 3 phits stored -> immediately empty=1, sent_req=0, outdata=0, state IDLE, route_req=0.
- Single packet: write head 0x1111, body 0x2222, tail 0x3333; route_req=1 until ok; then call_invc for 3 cycles -> outdata 0x1111/0x2222/0x3333 one cycle after each call, new=1 only with 0x1111, 3 credit_out pulses, then IDLE with empty=1.
- Fill and overflow: write 8 phits with no pops -> full=1. A 9th write -> dropped, overflow=1 sticky. The 8 popped phits match the written order.
- Simultaneous push/pop at full: write and call in the same cycle -> full stays 1, count=8, pointers wrap correctly, data order preserved across the wrap.
- Call without grant: call_invc while in REQ -> no pop, sent_req=0. Assert ok, then call -> first pop one cycle later.
- Bypass (macro defined): ACTIVE, empty, in_valid+call_invc with 0xABCD -> outdata=0xABCD next cycle, empty stays 1. With the macro undefined -> empty=0 and sent_req=0.

Source files
------------

// File: rtl/inport_vc_buffer_if.sv
// Handshake bundle for one VC input buffer: upstream write side, output-port call/grant side and status.
// Signal suffixes are from the buffer's point of view (slave modport).
interface inport_vc_buffer_if #(
    parameter int phit_size = 16
);
    logic [phit_size-1:0] in_data_i;
    logic                 in_valid_i;
    logic                 in_new_i;
    logic                 in_tail_i;
    logic                 call_invc_i;
    logic                 ok_i;

    logic [phit_size-1:0] outdata_o;
    logic                 new_o;
    logic                 sent_req_o;
    logic                 route_req_o;
    logic                 full_o;
    logic                 empty_o;
    logic                 credit_out_o;
    logic                 overflow_o;

    modport slave (
        input  in_data_i, in_valid_i, in_new_i, in_tail_i, call_invc_i, ok_i,
        output outdata_o, new_o, sent_req_o, route_req_o, full_o, empty_o,
               credit_out_o, overflow_o
    );

    modport master (
        output in_data_i, in_valid_i, in_new_i, in_tail_i, call_invc_i, ok_i,
        input  outdata_o, new_o, sent_req_o, route_req_o, full_o, empty_o,
               credit_out_o, overflow_o
    );
endinterface

// File: rtl/inport_vc_buffer.sv
// Per-VC input FIFO with packet-boundary FSM, route request and registered pop stage.
// Optional macro INPORT_VC_BUF_BYPASS_EN: empty-FIFO cut-through from in_data to the output register.
//
// state  | meaning
// IDLE   | waiting for a head phit at the FIFO front; non-head fronts are discarded
// REQ    | head at front, route_req raised until ok
// ACTIVE | packet granted, call_invc pops phits until the tail leaves
module inport_vc_buffer #(
    parameter int phit_size               = 16,
    parameter int buf_depth               = 8,
    parameter int log2_buf_depth          = 3,
    parameter int floorplusone_log2_no_vc = 4
) (
    input logic             clk,
    input logic             rst,
    inport_vc_buffer_if.slave bus
);
    localparam int ENTRY_W = phit_size + 2;
    localparam logic [log2_buf_depth:0] FULL_CNT = (log2_buf_depth + 1)'(buf_depth);

    if (buf_depth < 2 || buf_depth != (1 << log2_buf_depth) || floorplusone_log2_no_vc < 1)
    begin : g_bad_params
        $error("inport_vc_buffer: inconsistent depth or VC index parameters");
    end

    typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_e;

    state_e                    state_q, state_d;
    logic [ENTRY_W-1:0]        mem_q [buf_depth];
    logic [log2_buf_depth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [log2_buf_depth:0]   count_q, count_d;
    logic [phit_size-1:0]      outdata_q, outdata_d;
    logic                      new_q, new_d, sent_req_q, sent_req_d;
    logic                      credit_q, credit_d, overflow_q, overflow_d;

    logic               full, empty, pop, discard, bypass, rd_adv, wr_en;
    logic               front_new, front_tail;
    logic [ENTRY_W-1:0] front;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign front      = mem_q[rd_ptr_q];
    assign front_new  = front[phit_size];
    assign front_tail = front[phit_size+1];

`ifdef INPORT_VC_BUF_BYPASS_EN
    assign bypass = (state_q == ACTIVE) && empty && bus.in_valid_i && bus.call_invc_i;
`else
    assign bypass = 1'b0;
`endif

    assign pop     = bus.call_invc_i && !empty && (state_q == ACTIVE);
    // A body/tail phit with no preceding head can never be routed; drop it and return its credit.
    assign discard = (state_q == IDLE) && !empty && !front_new;
    assign rd_adv  = pop || discard;
    assign wr_en   = bus.in_valid_i && (!full || rd_adv) && !bypass;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {bus.in_tail_i, bus.in_new_i, bus.in_data_i};
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        outdata_d  = outdata_q;
        new_d      = 1'b0;
        sent_req_d = 1'b0;
        credit_d   = 1'b0;
        overflow_d = overflow_q;

        if (wr_en)  wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_adv) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_adv})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (bus.in_valid_i && full && !rd_adv) overflow_d = 1'b1;

        if (pop) begin
            outdata_d  = front[phit_size-1:0];
            new_d      = front_new;
            sent_req_d = 1'b1;
            credit_d   = 1'b1;
        end else if (bypass) begin
            outdata_d  = bus.in_data_i;
            new_d      = bus.in_new_i;
            sent_req_d = 1'b1;
            credit_d   = 1'b1;
        end else if (discard) begin
            credit_d   = 1'b1;
        end

        case (state_q)
            IDLE:    if (!empty && front_new) state_d = REQ;
            REQ:     if (bus.ok_i) state_d = ACTIVE;
            ACTIVE:  if ((pop && front_tail) || (bypass && bus.in_tail_i)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            outdata_q  <= '0;
            new_q      <= 1'b0;
            sent_req_q <= 1'b0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            outdata_q  <= outdata_d;
            new_q      <= new_d;
            sent_req_q <= sent_req_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.outdata_o    = outdata_q;
    assign bus.new_o        = new_q;
    assign bus.sent_req_o   = sent_req_q;
    assign bus.route_req_o  = (state_q == REQ);
    assign bus.full_o       = full;
    assign bus.empty_o      = empty;
    assign bus.credit_out_o = credit_q;
    assign bus.overflow_o   = overflow_q;
endmodule

// File: tb/tb_inport_vc_buffer.sv
// Directed plus randomized bench for inport_vc_buffer against a queue-based packet model.
// Follows INPORT_VC_BUF_BYPASS_EN the same way as the design.
module tb_inport_vc_buffer;
    localparam int PW    = 16;
    localparam int DEPTH = 8;
`ifdef INPORT_VC_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inport_vc_buffer_if #(.phit_size(PW)) bus ();

    inport_vc_buffer #(
        .phit_size(PW), .buf_depth(DEPTH), .log2_buf_depth(3), .floorplusone_log2_no_vc(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef enum {WAIT_HEAD, WAIT_GRANT, STREAM} phase_e;

    logic [PW+1:0]  q[$];
    phase_e         ph;
    logic [PW-1:0]  m_out;
    logic           m_new, m_sent, m_credit, m_ovf;
    int             n_tests = 0;
    int             n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ph       = WAIT_HEAD;
        m_out    = '0;
        m_new    = 1'b0;
        m_sent   = 1'b0;
        m_credit = 1'b0;
        m_ovf    = 1'b0;
    endtask

    // One clock of the packet model, using the inputs currently on the bus.
    task automatic model_step();
        int            sz = q.size();
        logic [PW+1:0] front;
        bit            popped = 1'b0;
        bit            byp = 1'b0;
        phase_e        nph = ph;
        front    = (sz > 0) ? q[0] : '0;
        m_sent   = 1'b0;
        m_new    = 1'b0;
        m_credit = 1'b0;
        if (ph == STREAM && bus.call_invc_i && sz > 0) begin
            void'(q.pop_front());
            m_out = front[PW-1:0]; m_new = front[PW]; m_sent = 1'b1; m_credit = 1'b1;
            popped = 1'b1;
            if (front[PW+1]) nph = WAIT_HEAD;
        end else if (BYP && ph == STREAM && sz == 0 && bus.in_valid_i && bus.call_invc_i) begin
            m_out = bus.in_data_i; m_new = bus.in_new_i; m_sent = 1'b1; m_credit = 1'b1;
            byp = 1'b1;
            if (bus.in_tail_i) nph = WAIT_HEAD;
        end else if (ph == WAIT_HEAD && sz > 0 && !front[PW]) begin
            void'(q.pop_front());
            m_credit = 1'b1;
            popped = 1'b1;
        end
        if (ph == WAIT_HEAD && sz > 0 && front[PW]) nph = WAIT_GRANT;
        if (ph == WAIT_GRANT && bus.ok_i) nph = STREAM;
        if (bus.in_valid_i && !byp) begin
            if (sz < DEPTH || popped) q.push_back({bus.in_tail_i, bus.in_new_i, bus.in_data_i});
            else m_ovf = 1'b1;
        end
        ph = nph;
    endtask

    task automatic check_comb();
        chk("route_req", bus.route_req_o, ph == WAIT_GRANT);
        chk("full", bus.full_o, q.size() == DEPTH);
        chk("empty", bus.empty_o, q.size() == 0);
    endtask

    task automatic check_regs();
        chk("outdata", bus.outdata_o, m_out);
        chk("new", bus.new_o, m_new);
        chk("sent_req", bus.sent_req_o, m_sent);
        chk("credit_out", bus.credit_out_o, m_credit);
        chk("overflow", bus.overflow_o, m_ovf);
    endtask

    task automatic cycle();
        check_comb();
        model_step();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic drive(input bit v, input logic [PW-1:0] d, input bit n, input bit t,
                         input bit c, input bit o);
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.in_new_i    = n;
        bus.in_tail_i   = t;
        bus.call_invc_i = c;
        bus.ok_i        = o;
        cycle();
    endtask

    initial begin
        bit            v, n, t, in_pkt;
        int            left;
        logic [PW-1:0] d;

        rst = 1'b1;
        bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.in_new_i = 1'b0;
        bus.in_tail_i = 1'b0; bus.call_invc_i = 1'b0; bus.ok_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        check_comb();
        @(negedge clk);
        rst = 1'b0;

        // single three-phit packet
        drive(1, 16'h1111, 1, 0, 0, 0);
        drive(1, 16'h2222, 0, 0, 0, 0);
        drive(1, 16'h3333, 0, 1, 0, 0);
        chk("sp_route_req", bus.route_req_o, 1'b1);
        drive(0, 16'h0, 0, 0, 0, 0);
        drive(0, 16'h0, 0, 0, 0, 1);
        drive(0, 16'h0, 0, 0, 1, 0);
        chk("sp_out0", bus.outdata_o, 16'h1111);
        chk("sp_new0", bus.new_o, 1'b1);
        drive(0, 16'h0, 0, 0, 1, 0);
        chk("sp_out1", bus.outdata_o, 16'h2222);
        chk("sp_new1", bus.new_o, 1'b0);
        drive(0, 16'h0, 0, 0, 1, 0);
        chk("sp_out2", bus.outdata_o, 16'h3333);
        chk("sp_credit2", bus.credit_out_o, 1'b1);
        drive(0, 16'h0, 0, 0, 0, 0);
        chk("sp_empty", bus.empty_o, 1'b1);
        chk("sp_idle", bus.route_req_o, 1'b0);

        // call before grant is ignored
        drive(1, 16'h4444, 1, 1, 0, 0);
        drive(0, 16'h0, 0, 0, 0, 0);
        drive(0, 16'h0, 0, 0, 1, 0);
        chk("ng_sent", bus.sent_req_o, 1'b0);
        drive(0, 16'h0, 0, 0, 0, 1);
        drive(0, 16'h0, 0, 0, 1, 0);
        chk("ng_out", bus.outdata_o, 16'h4444);
        chk("ng_sent1", bus.sent_req_o, 1'b1);

        // fill to full, then one write too many
        for (int i = 0; i < DEPTH; i++)
            drive(1, 16'h5000 + 16'(i), i == 0, i == DEPTH - 1, 0, 0);
        chk("fill_full", bus.full_o, 1'b1);
        drive(1, 16'h50FF, 0, 0, 0, 0);
        chk("ovf_set", bus.overflow_o, 1'b1);
        drive(0, 16'h0, 0, 0, 0, 1);

        // push and pop together while full, across the pointer wrap
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'h6000 + 16'(i), i == 0, 0, 1, 0);
            chk("pp_full", bus.full_o, 1'b1);
            chk("pp_out", bus.outdata_o, 16'h5000 + 16'(i));
        end
        for (int i = 0; i < 14; i++) drive(0, 16'h0, 0, 0, 1, 1);

        // asynchronous reset in mid-cycle with three phits stored
        drive(1, 16'h7000, 1, 0, 0, 0);
        drive(1, 16'h7001, 0, 0, 0, 0);
        drive(1, 16'h7002, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_empty", bus.empty_o, 1'b1);
        chk("rst_sent", bus.sent_req_o, 1'b0);
        chk("rst_out", bus.outdata_o, 16'h0);
        chk("rst_route", bus.route_req_o, 1'b0);
        chk("rst_ovf", bus.overflow_o, 1'b0);
        bus.in_valid_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // bypass candidate: granted packet with an empty FIFO
        drive(1, 16'h8000, 1, 0, 0, 0);
        drive(0, 16'h0, 0, 0, 0, 0);
        drive(0, 16'h0, 0, 0, 0, 1);
        drive(0, 16'h0, 0, 0, 1, 0);
        drive(1, 16'hABCD, 0, 1, 1, 0);
`ifdef INPORT_VC_BUF_BYPASS_EN
        chk("byp_out", bus.outdata_o, 16'hABCD);
        chk("byp_empty", bus.empty_o, 1'b1);
`else
        chk("nobyp_empty", bus.empty_o, 1'b0);
        chk("nobyp_sent", bus.sent_req_o, 1'b0);
`endif
        for (int i = 0; i < 3; i++) drive(0, 16'h0, 0, 0, 1, 0);

        // randomized traffic, including stray non-head phits and overflow pressure
        in_pkt = 1'b0;
        left   = 0;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 2) != 0);
            d = 16'($urandom);
            n = 1'b0;
            t = 1'b0;
            if (v) begin
                if (!in_pkt) begin
                    if ($urandom_range(0, 15) != 0) begin
                        left = $urandom_range(1, 4);
                        n = 1'b1;
                        t = (left == 1);
                        left--;
                        in_pkt = !t;
                    end
                end else begin
                    t = (left == 1);
                    left--;
                    in_pkt = !t;
                end
            end
            drive(v, d, n, t, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
